// File: rtl/io_arb_pkg.sv
// Shared constants and the registered memory-command type for the I/O port arbiter.
package io_arb_pkg;

  localparam int REQ_VGA = 0;
  localparam int REQ_KBD = 1;
  localparam int REQ_DBG = 2;

  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_STARVE_LIMIT = 8;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic              wren;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } io_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping,
// reported as a one-hot grant plus the winner's index.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int cand;

  // NOTE: every output gets a default before the search loop, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = W'(cand);
      end
    end
  end

endmodule

// File: rtl/io_port_arbiter.sv
// Shares memory port B between a fixed-priority requester 0 and round-robin
// requesters 1..N_REQ-1, with a starvation guard and tagged read-data return.
module io_port_arbiter
  import io_arb_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_wren,
  input  logic [N_REQ*DATA_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [DATA_W-1:0]       io_addr,
  output logic                    io_wren,
  output logic [DATA_W-1:0]       io_wdata,
  input  logic [DATA_W-1:0]       io_rdata
);

  localparam int NO = N_REQ - 1;
  localparam int PW = $clog2(N_REQ);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [PW-1:0] FIRST_RR   = PW'(REQ_KBD);
  localparam logic [PW-1:0] LAST_LOCAL = PW'(NO - 1);
  localparam logic [SW-1:0] LIMIT      = SW'(STARVE_LIMIT);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] starve_q, starve_d;
  io_cmd_t       io_q, io_d, sel;
  logic [N_REQ-1:0] tag_q [READ_LATENCY+1];
  logic [N_REQ-1:0] tag_d [READ_LATENCY+1];

  logic [NO-1:0] pick_gnt;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] pick_ptr;
  logic          pick_any;
  logic          acc;

  // rr_ptr_q holds a requester number (1..N_REQ-1); the picker works in 0-based slots.
  assign pick_ptr = rr_ptr_q - FIRST_RR;

  rr_pick #(.N(NO), .W(PW)) u_pick (
    .req (req[N_REQ-1:1]),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (req[REQ_VGA] && (starve_q < LIMIT)) gnt[REQ_VGA] = 1'b1;
      else if (pick_any)                      gnt = {pick_gnt, 1'b0};
      else if (req[REQ_VGA])                  gnt[REQ_VGA] = 1'b1;
    end
  end

  assign acc = |(req & gnt);

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel = {req_wren[i], req_addr[DATA_W*i +: DATA_W], req_wdata[DATA_W*i +: DATA_W]};
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    starve_d     = starve_q;
    io_d         = io_q;
    io_d.wren    = 1'b0;
    if (acc) io_d = sel;
    if (|gnt[N_REQ-1:1]) begin
      rr_ptr_d = (pick_idx == LAST_LOCAL) ? FIRST_RR : pick_idx + PW'(2);
      starve_d = '0;
    end else if (!pick_any) begin
      starve_d = '0;
    end else if (gnt[REQ_VGA] && (starve_q < LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Writes push an empty tag so the pipe stays aligned with memory latency.
  always_comb begin
    tag_d[0] = (acc && !sel.wren) ? gnt : '0;
    for (int i = 1; i <= READ_LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= FIRST_RR;
      starve_q <= '0;
      io_q     <= '0;
      // NOTE: the tag pipe is a small array but must be cleared; a stale tag
      // would strobe rvalid for a read that reset already dropped.
      for (int i = 0; i <= READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      io_q     <= io_d;
      for (int i = 0; i <= READ_LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign io_addr  = io_q.addr;
  assign io_wren  = io_q.wren;
  assign io_wdata = io_q.wdata;
  assign rvalid   = tag_q[READ_LATENCY];
  assign rdata    = io_rdata;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed bench for io_port_arbiter with a one-cycle synchronous memory model.
module tb_io_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  req_wren = '0;
  logic [95:0] req_addr = '0;
  logic [95:0] req_wdata = '0;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [31:0] rdata;
  logic [31:0] io_addr;
  logic        io_wren;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata = '0;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  io_port_arbiter #(.N_REQ(3), .READ_LATENCY(1), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wren(req_wren), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .io_addr(io_addr), .io_wren(io_wren), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (io_wren) mem[io_addr[7:0]] <= io_wdata;
    io_rdata <= mem[io_addr[7:0]];
  end

  task automatic set_payload(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_wren[i]         = w;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; req_wren = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 3'b111;
    #1;
    n_checks++; if (gnt !== 3'b000) begin n_errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    @(negedge clk); #1;
    n_checks++; if (io_addr !== 32'h0) begin n_errors++; $display("FAIL reset_io_addr: got %h expected 0", io_addr); end
    n_checks++; if (io_wren !== 1'b0) begin n_errors++; $display("FAIL reset_io_wren: got %b expected 0", io_wren); end
    n_checks++; if (io_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_io_wdata: got %h expected 0", io_wdata); end
    n_checks++; if (rvalid !== 3'b000) begin n_errors++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
    rst = 1'b0; #1;
    n_checks++; if (gnt !== 3'b001) begin n_errors++; $display("FAIL reset_all_req_gnt: got %b expected 001", gnt); end
    req = '0;
  endtask

  task automatic test_single_read();
    apply_reset();
    set_payload(1, 1'b0, 32'h20, 32'h0);
    req = 3'b010; #1;
    n_checks++; if (gnt !== 3'b010) begin n_errors++; $display("FAIL rd_gnt: got %b expected 010", gnt); end
    @(negedge clk); req = '0; #1;
    n_checks++; if (io_addr !== 32'h20) begin n_errors++; $display("FAIL rd_io_addr: got %h expected 20", io_addr); end
    n_checks++; if (io_wren !== 1'b0) begin n_errors++; $display("FAIL rd_io_wren: got %b expected 0", io_wren); end
    n_checks++; if (rvalid !== 3'b000) begin n_errors++; $display("FAIL rd_rvalid_early: got %b expected 000", rvalid); end
    @(negedge clk); #1;
    n_checks++; if (rvalid !== 3'b010) begin n_errors++; $display("FAIL rd_rvalid: got %b expected 010", rvalid); end
    n_checks++; if (rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_rdata: got %h expected deadbeef", rdata); end
    @(negedge clk); #1;
    n_checks++; if (rvalid !== 3'b000) begin n_errors++; $display("FAIL rd_rvalid_once: got %b expected 000", rvalid); end
  endtask

  task automatic test_write_read();
    apply_reset();
    set_payload(2, 1'b1, 32'h40, 32'h12345678);
    req = 3'b100; #1;
    n_checks++; if (gnt !== 3'b100) begin n_errors++; $display("FAIL wr_gnt: got %b expected 100", gnt); end
    @(negedge clk); set_payload(2, 1'b0, 32'h40, 32'h0); #1;
    n_checks++; if (gnt !== 3'b100) begin n_errors++; $display("FAIL wr_rd_gnt: got %b expected 100", gnt); end
    n_checks++; if (io_wren !== 1'b1) begin n_errors++; $display("FAIL wr_io_wren: got %b expected 1", io_wren); end
    n_checks++; if (io_addr !== 32'h40) begin n_errors++; $display("FAIL wr_io_addr: got %h expected 40", io_addr); end
    n_checks++; if (io_wdata !== 32'h12345678) begin n_errors++; $display("FAIL wr_io_wdata: got %h expected 12345678", io_wdata); end
    @(negedge clk); req = '0; #1;
    n_checks++; if (io_wren !== 1'b0) begin n_errors++; $display("FAIL wr_io_wren_once: got %b expected 0", io_wren); end
    n_checks++; if (rvalid !== 3'b000) begin n_errors++; $display("FAIL wr_no_rvalid: got %b expected 000", rvalid); end
    @(negedge clk); #1;
    n_checks++; if (rvalid !== 3'b100) begin n_errors++; $display("FAIL raw_rvalid: got %b expected 100", rvalid); end
    n_checks++; if (rdata !== 32'h12345678) begin n_errors++; $display("FAIL raw_rdata: got %h expected 12345678", rdata); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b010; exp_g[3] = 3'b100;
    apply_reset();
    set_payload(1, 1'b0, 32'h24, 32'h0);
    set_payload(2, 1'b0, 32'h28, 32'h0);
    req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++; if (gnt !== exp_g[i]) begin n_errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, exp_g[i]); end
    end
    @(negedge clk); req = '0;
  endtask

  task automatic test_starvation();
    logic [2:0] exp_g [26];
    apply_reset();
    set_payload(0, 1'b0, 32'h10, 32'h0);
    set_payload(1, 1'b0, 32'h14, 32'h0);
    req = 3'b011;
    for (int i = 0; i < 26; i++) begin
      exp_g[i] = ((i % 9) == 8) ? 3'b010 : 3'b001;
      if (i > 0) @(negedge clk);
      #1;
      n_checks++; if (gnt !== exp_g[i]) begin n_errors++; $display("FAIL starve_gnt[%0d]: got %b expected %b", i, gnt, exp_g[i]); end
      if (i >= 2) begin
        n_checks++; if (rvalid !== exp_g[i-2]) begin n_errors++; $display("FAIL starve_rvalid[%0d]: got %b expected %b", i, rvalid, exp_g[i-2]); end
      end
    end
    // Counter is saturated here; a lone requester 0 must still be served.
    @(negedge clk); req = 3'b001; #1;
    n_checks++; if (gnt !== 3'b001) begin n_errors++; $display("FAIL starve_lone_vga: got %b expected 001", gnt); end
    @(negedge clk); req = 3'b011; #1;
    n_checks++; if (gnt !== 3'b001) begin n_errors++; $display("FAIL starve_cleared: got %b expected 001", gnt); end
    @(negedge clk); req = '0;
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    set_payload(1, 1'b0, 32'h20, 32'h0);
    set_payload(2, 1'b0, 32'h28, 32'h0);
    req = 3'b010; #1;
    n_checks++; if (gnt !== 3'b010) begin n_errors++; $display("FAIL mid_gnt: got %b expected 010", gnt); end
    @(negedge clk); rst = 1'b1; req = 3'b110; #1;
    n_checks++; if (gnt !== 3'b000) begin n_errors++; $display("FAIL mid_gnt_in_rst: got %b expected 000", gnt); end
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (rvalid !== 3'b000) begin n_errors++; $display("FAIL mid_rvalid_dropped: got %b expected 000", rvalid); end
    n_checks++; if (io_wren !== 1'b0) begin n_errors++; $display("FAIL mid_io_wren: got %b expected 0", io_wren); end
    n_checks++; if (io_addr !== 32'h0) begin n_errors++; $display("FAIL mid_io_addr: got %h expected 0", io_addr); end
    n_checks++; if (gnt !== 3'b010) begin n_errors++; $display("FAIL mid_first_gnt: got %b expected 010", gnt); end
    @(negedge clk); req = '0; #1;
    n_checks++; if (rvalid !== 3'b000) begin n_errors++; $display("FAIL mid_rvalid_t3: got %b expected 000", rvalid); end
    @(negedge clk); #1;
    n_checks++; if (rvalid !== 3'b010) begin n_errors++; $display("FAIL mid_post_rvalid: got %b expected 010", rvalid); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h20] = 32'hDEADBEEF;
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_starvation();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
